pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage. It is the successor of the fixed 32-bit PC register.
- Holds the PC and selects the next value from sequential increment, external redirect, call target or return.
- Adds stall hold and a small circular return-address stack (RAS).
- Instantiated once per core, ahead of instruction memory.

---
 rtl/pc_pkg.sv | 18 +
 rtl/ras_stack.sv | 76 +++++++
 rtl/pc_unit.sv | 100 ++++++++++
 tb/tb_pc_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package pc_pkg;

  localparam int unsigned PC_WIDTH     = 32;
  localparam int unsigned PC_INC       = 4;
  localparam int unsigned PC_RESET_VEC = 0;

  // Next-PC source chosen by the priority decode.
  typedef enum logic [2:0] {
    SEL_SEQ       = 3'd0,
    SEL_REDIRECT  = 3'd1,
    SEL_CALL      = 3'd2,
    SEL_RET       = 3'd3,
    SEL_RET_EMPTY = 3'd4,
    SEL_HOLD      = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push writes at ptr+1, pop reads at ptr.
module ras_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       replace,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    ptr_n;
  logic [AW-1:0]    ptr_inc;
  logic [CW-1:0]    count_n;
  logic             wr_new;
  logic             wr_top;

  // Replace on an empty stack has nothing to replace, so it becomes a push.
  assign wr_new    = push | (replace & empty);
  assign wr_top    = replace & ~empty;
  assign ptr_inc   = ptr + AW'(1);
  assign rdata     = mem[ptr];
  assign overflow  = wr_new & full;
  assign underflow = pop & empty & ~wr_new & ~replace;

  always_comb begin
    ptr_n   = ptr;
    count_n = count;
    if (wr_new) begin
      ptr_n = ptr_inc;
      if (!full) count_n = count + CW'(1);
    end else if (wr_top) begin
      ptr_n   = ptr;
      count_n = count;
    end else if (pop && !empty) begin
      ptr_n   = ptr - AW'(1);
      count_n = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      ptr   <= ptr_n;
      count <= count_n;
      empty <= (count_n == CW'(0));
      full  <= (count_n == CW'(DEPTH));
    end
  end

  // Storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (wr_new)      mem[ptr_inc] <= wdata;
      else if (wr_top) mem[ptr]     <= wdata;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, stall, call/return and a circular RAS.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter int unsigned INC       = PC_INC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [WIDTH-1:0]            redirect_target,
  input  logic                        call,
  input  logic [WIDTH-1:0]            call_target,
  input  logic                        ret,
  output logic [WIDTH-1:0]            pc,
  output logic [WIDTH-1:0]            pc_plus,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_empty,
  output logic                        ras_full,
  output logic                        err_overflow,
  output logic                        err_underflow
);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_n;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;
  logic             ras_ovf;
  logic             ras_unf;

  assign pc_plus = pc + WIDTH'(INC);

  // Priority decode: redirect > stall > call(+ret) > ret > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (redirect_valid)  sel = SEL_REDIRECT;
    else if (stall)      sel = SEL_HOLD;
    else if (call)       sel = SEL_CALL;
    else if (ret)        sel = ras_empty ? SEL_RET_EMPTY : SEL_RET;
  end

  always_comb begin
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    ras_replace = 1'b0;
    pc_n        = pc_plus;
    unique case (sel)
      SEL_REDIRECT:  pc_n = redirect_target;
      SEL_HOLD:      pc_n = pc;
      SEL_CALL: begin
        pc_n        = call_target;
        ras_push    = ~ret;
        ras_replace = ret;
      end
      SEL_RET: begin
        pc_n    = ras_top;
        ras_pop = 1'b1;
      end
      SEL_RET_EMPTY: pc_n = pc_plus;
      default:       pc_n = pc_plus;
    endcase
  end

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .replace   (ras_replace),
    .wdata     (pc_plus),
    .rdata     (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  // PC register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc            <= RESET_VEC;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      pc            <= pc_n;
      err_overflow  <= err_overflow | ras_ovf;
      err_underflow <= err_underflow | (sel == SEL_RET_EMPTY) | ras_unf;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        call;
  logic [31:0] call_target;
  logic        ret;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [2:0]  ras_count;
  logic        ras_empty;
  logic        ras_full;
  logic        err_overflow;
  logic        err_underflow;

  int tests  = 0;
  int failed = 0;

  pc_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .call            (call),
    .call_target     (call_target),
    .ret             (ret),
    .pc              (pc),
    .pc_plus         (pc_plus),
    .ras_count       (ras_count),
    .ras_empty       (ras_empty),
    .ras_full        (ras_full),
    .err_overflow    (err_overflow),
    .err_underflow   (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    call           = 1'b0;
    ret            = 1'b0;
    stall          = 1'b0;
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    step();
  endtask

  task automatic do_call(input logic [31:0] t);
    call        = 1'b1;
    call_target = t;
    step();
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    call = 1'b0; call_target = '0; ret = 1'b0;
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_count", 32'(ras_count), 32'd0);
    chk("rst_empty", 32'(ras_empty), 32'd1);
    chk("rst_full", 32'(ras_full), 32'd0);
    chk("rst_ovf", 32'(err_overflow), 32'd0);
    chk("rst_unf", 32'(err_underflow), 32'd0);
    rst = 1'b1;

    // Sequential run
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("seq_pc", pc, 32'(i * 4));
    end
    redir(32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_plus", pc_plus, 32'h0);
    step();
    chk("wrap_next", pc, 32'h0);

    // Stall vs redirect
    redir(32'h10);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      step();
      chk("stall_pc", pc, 32'h10);
    end
    stall = 1'b1;
    redir(32'h200);
    chk("stall_redir_pc", pc, 32'h200);
    chk("stall_redir_cnt", 32'(ras_count), 32'd0);

    // Call / return
    redir(32'h40);
    do_call(32'h100);
    chk("call_pc", pc, 32'h100);
    chk("call_cnt", 32'(ras_count), 32'd1);
    step();
    chk("call_seq1", pc, 32'h104);
    step();
    chk("call_seq2", pc, 32'h108);
    ret = 1'b1;
    step();
    chk("ret_pc", pc, 32'h44);
    chk("ret_cnt", 32'(ras_count), 32'd0);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // Overflow: five nested calls into a four-entry stack
    redir(32'h0);
    do_call(32'h100);
    do_call(32'h200);
    do_call(32'h300);
    do_call(32'h400);
    chk("full_flag", 32'(ras_full), 32'd1);
    chk("no_ovf_yet", 32'(err_overflow), 32'd0);
    do_call(32'h500);
    chk("ovf_pc", pc, 32'h500);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_cnt", 32'(ras_count), 32'd4);
    ret = 1'b1; step(); chk("ovf_ret1", pc, 32'h404);
    ret = 1'b1; step(); chk("ovf_ret2", pc, 32'h304);
    ret = 1'b1; step(); chk("ovf_ret3", pc, 32'h204);
    ret = 1'b1; step(); chk("ovf_ret4", pc, 32'h104);
    chk("ovf_empty", 32'(ras_empty), 32'd1);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);

    // Underflow
    redir(32'h80);
    chk("unf_pre", 32'(err_underflow), 32'd0);
    ret = 1'b1;
    step();
    chk("unf_pc", pc, 32'h84);
    chk("unf_flag", 32'(err_underflow), 32'd1);
    chk("unf_cnt", 32'(ras_count), 32'd0);

    // Call+ret replaces the top entry
    redir(32'h40);
    do_call(32'h90);
    chk("cr_setup_cnt", 32'(ras_count), 32'd1);
    ret = 1'b1;
    do_call(32'h300);
    chk("cr_pc", pc, 32'h300);
    chk("cr_cnt", 32'(ras_count), 32'd1);
    ret = 1'b1;
    step();
    chk("cr_top", pc, 32'h94);
    chk("cr_empty", 32'(ras_empty), 32'd1);

    // Reset together with a call
    redir(32'h4C);
    do_call(32'h50);
    chk("mid_setup_cnt", 32'(ras_count), 32'd1);
    rst = 1'b0;
    do_call(32'h999);
    chk("mid_pc", pc, 32'h0);
    chk("mid_cnt", 32'(ras_count), 32'd0);
    chk("mid_ovf", 32'(err_overflow), 32'd0);
    chk("mid_unf", 32'(err_underflow), 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_pc", pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
